// File: rtl/retospect_lif_core.sv
// Leaky integrate-and-fire neuron: weighted spike integration, tick-driven decay, threshold fire, refractory hold.
// Latency: in_spk sampled at edge N produces spike_out high from edge N to edge N+1 (one registered stage).
// Backpressure: none; config_en freezes all dynamic state and suppresses spike_out while configuration shifts.
module retospect_lif_core #(
   parameter int W_BITS         = 3,
   parameter int UT_BITS        = 4,
   parameter int MEM_BITS       = 6,
   parameter int REFRACT_CYCLES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                reset_nn,
   input  logic                config_en,
   input  logic [W_BITS-1:0]   w1,
   input  logic [W_BITS-1:0]   w2,
   input  logic [W_BITS-1:0]   w3,
   input  logic [W_BITS-1:0]   w4,
   input  logic [UT_BITS-1:0]  u_t,
   input  logic [2:0]          decay_sel,
   input  logic [7:0]          clockbus,
   input  logic [3:0]          in_spk,
   output logic                spike_out,
   output logic [MEM_BITS-1:0] membrane,
   output logic [7:0]          spike_count,
   output logic                refractory
);

   // Two extra bits hold the signed sum of membrane plus worst-case synaptic drive.
   localparam int SUM_BITS = MEM_BITS + 2;
   localparam int CNT_BITS = (REFRACT_CYCLES < 2) ? 1 : $clog2(REFRACT_CYCLES + 1);
   localparam logic [MEM_BITS-1:0] MEM_MAX  = '1;
   localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(REFRACT_CYCLES);
   localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

   typedef enum logic {
      ST_INTEGRATE = 1'b0,
      ST_REFRACT   = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic [CNT_BITS-1:0]      cnt_q, cnt_d;
   logic [MEM_BITS-1:0]      membrane_q, membrane_d;
   logic                     spike_q, spike_d;
   logic [7:0]               count_q, count_d;

   logic signed [SUM_BITS-1:0] syn;
   logic signed [SUM_BITS-1:0] dec;
   logic signed [SUM_BITS-1:0] sum;
   logic [MEM_BITS-1:0]        nxt;
   logic [MEM_BITS-1:0]        ut_ext;
   logic                       fire_hit;

   function automatic logic signed [SUM_BITS-1:0] sext_w(input logic [W_BITS-1:0] w);
      sext_w = {{(SUM_BITS - W_BITS){w[W_BITS-1]}}, w};
   endfunction

   // Candidate next membrane: add active weights, subtract one decay tick, clamp to the unsigned range.
   always_comb begin
      syn = '0;
      if (in_spk[0]) syn = syn + sext_w(w1);
      if (in_spk[1]) syn = syn + sext_w(w2);
      if (in_spk[2]) syn = syn + sext_w(w3);
      if (in_spk[3]) syn = syn + sext_w(w4);
      dec = {{(SUM_BITS - 1){1'b0}}, (clockbus[decay_sel] && (membrane_q != '0))};
      sum = $signed({2'b00, membrane_q}) + syn - dec;
      if (sum[SUM_BITS-1])
         nxt = '0;
      else if (sum > $signed({2'b00, MEM_MAX}))
         nxt = MEM_MAX;
      else
         nxt = sum[MEM_BITS-1:0];
      ut_ext   = {{(MEM_BITS - UT_BITS){1'b0}}, u_t};
      fire_hit = (nxt >= ut_ext);
   end

   // State register: async reset wins over everything, including an in-progress refractory period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_INTEGRATE;
         cnt_q      <= '0;
         membrane_q <= '0;
         spike_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         membrane_q <= membrane_d;
         spike_q    <= spike_d;
         count_q    <= count_d;
      end
   end

   // Next-state: network reset, then configuration freeze, then integrate/refractory behaviour.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      membrane_d = membrane_q;
      spike_d    = 1'b0;
      count_d    = count_q;
      if (reset_nn) begin
         state_d    = ST_INTEGRATE;
         cnt_d      = '0;
         membrane_d = '0;
         count_d    = '0;
      end else if (config_en) begin
         spike_d = 1'b0;
      end else begin
         case (state_q)
            ST_INTEGRATE: begin
               if (fire_hit) begin
                  state_d    = ST_REFRACT;
                  cnt_d      = CNT_LOAD;
                  membrane_d = '0;
                  spike_d    = 1'b1;
                  if (count_q != 8'hFF) count_d = count_q + 8'd1;
               end else begin
                  membrane_d = nxt;
               end
            end
            ST_REFRACT: begin
               membrane_d = '0;
               if (cnt_q <= CNT_ONE) begin
                  state_d = ST_INTEGRATE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_d = ST_INTEGRATE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs are taken straight from registers; refractory decodes the state.
   always_comb begin
      spike_out   = spike_q;
      membrane    = membrane_q;
      spike_count = count_q;
      refractory  = (state_q == ST_REFRACT);
   end

endmodule
